// File: rtl/dmem_ctrl.sv
// dmem_ctrl: parametrised single-port synchronous data memory for the RISC datapath MEM stage.
//
// Accepts one request per cycle over a valid/ready handshake. Every accepted request, whether a
// read or a write, produces exactly one rsp_valid pulse RD_LAT cycles after its acceptance edge.
// Responses come back in order. Writes honour per-byte enables. Addresses >= DEPTH are reported
// through rsp_err and leave the memory untouched.
//
// Optional feature, enabled by defining the macro DMEM_CLEAR_EN: after reset the controller sweeps
// zeros through every word, one word per cycle. It holds req_ready low for DEPTH cycles while the
// sweep runs.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  controller can accept a request this cycle
//   req_we     in   1 = write, 0 = read
//   req_be     in   [DATA_W/8] byte write enables (ignored on reads)
//   req_addr   in   [ADDR_W] word address
//   req_wdata  in   [DATA_W] write data
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  [DATA_W] read data, 0 for writes and errored requests; held while idle
//   rsp_err    out  address out of range, qualified by rsp_valid; held while idle
//   busy       out  request in flight or clear sweep active
module dmem_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DMEM_CLEAR_EN
  typedef enum logic [0:0] {StRun, StClear} state_e;
  localparam state_e StReset = StClear;
`else
  typedef enum logic [0:0] {StRun} state_e;
  localparam state_e StReset = StRun;
`endif

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] rd_word;

  // Response pipeline; stage 0 holds the registered array read, the last stage drives the outputs.
  logic [RD_LAT-1:0] vld_q;
  logic              err_q [RD_LAT];
  logic [DATA_W-1:0] dat_q [RD_LAT];

`ifdef DMEM_CLEAR_EN
  logic [IW-1:0] clr_q, clr_d;
  logic          clr_we;
`endif

  // Full-width compare, so high address bits can never alias back into the array.
  assign in_range = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
  assign idx      = req_addr[IW-1:0];
  assign accept   = req_valid && req_ready && !rst;
  assign wr_en    = accept && req_we && in_range;
  // Read-before-write: the array read below sees the contents from before this edge's write.
  assign rd_word  = (req_we || !in_range) ? '0 : mem[idx];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DMEM_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q <= '0;
    end else begin
      clr_q <= clr_d;
    end
  end
`endif

  // Next-state and handshake.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
`ifdef DMEM_CLEAR_EN
    clr_d     = clr_q;
    clr_we    = 1'b0;
`endif
    unique case (state_q)
      StRun: req_ready = 1'b1;
`ifdef DMEM_CLEAR_EN
      StClear: begin
        clr_we = 1'b1;
        if (clr_q == IW'(DEPTH - 1)) begin
          state_d = StRun;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
`endif
      default: state_d = StReset;
    endcase
  end

  // Storage; contents are intentionally not reset.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (clr_we && !rst) begin
      mem[clr_q] <= '0;
    end
`endif
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Payload moves only alongside a valid bit, so the output stage holds its last response.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        err_q[k] <= 1'b0;
        dat_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      if (accept) begin
        err_q[0] <= !in_range;
        dat_q[0] <= rd_word;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          err_q[k] <= err_q[k-1];
          dat_q[k] <= dat_q[k-1];
        end
      end
    end
  end

  assign rsp_valid = vld_q[RD_LAT-1];
  assign rsp_err   = err_q[RD_LAT-1];
  assign rsp_rdata = dat_q[RD_LAT-1];
  assign busy      = (|vld_q) || (state_q != StRun);

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised single-port synchronous data memory for the 32-bit RISC datapath.
- Generalises the fixed 32x64 data RAM with:
  - configurable data width, depth and read latency;
  - per-byte write strobes;
  - a valid/ready request interface and a response pulse for both reads and writes;
  - out-of-range address error reporting.
- Sits between the MEM stage and the data storage; fully pipelined, one request per cycle.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, width of the word-address port.
- DEPTH, 64, number of words implemented; DEPTH <= 2**ADDR_W.
- RD_LAT, 1, request-to-response latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  DATA_W/8  byte write enables; bit i covers bits [8i+7:8i]; ignored on reads.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errored requests.
- rsp_err  out  1  qualified by rsp_valid; 1 = address out of range.
- busy  out  1  request in flight or clear sweep active.

Behaviour:
- Reset (rst sampled high): rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, all pipeline stages invalidated.
  - req_ready=1 from the first cycle after reset, unless DMEM_CLEAR_EN is defined.
  - Memory contents are not reset.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. No backpressure on the response side.
- State machine:
  - RUN: req_ready=1.
  - CLEAR: exists only with DMEM_CLEAR_EN; see Optional Feature.
- Write, addr < DEPTH:
  - Each byte lane with req_be[i]=1 is updated at the acceptance edge; other lanes are unchanged.
  - req_be=0 is legal: memory is unchanged, a response is still issued.
- Read, addr < DEPTH: rsp_rdata = word contents at the acceptance edge, before any write accepted on that same edge (single port, so only one request per edge).
- Ordering: a read accepted the cycle after a write to the same address returns the new data.
- Out of range, addr >= DEPTH: memory unchanged; response carries rsp_err=1 and rsp_rdata=0.
- Latency: every accepted request produces exactly one rsp_valid pulse exactly RD_LAT cycles after its acceptance edge.
  - Responses are returned in order.
  - Back-to-back requests produce back-to-back pulses.
  - RD_LAT=1 matches the legacy timing: data registered on the edge after acceptance.
- Pipeline: RD_LAT-deep shift register of {valid, err, rdata}; the stage-1 rdata is the registered array read.
  - rsp_rdata/rsp_err hold their last values while rsp_valid=0.
- busy = OR of all pipeline valid bits, OR state==CLEAR.
- Reset mid-operation: all in-flight responses are dropped and no rsp_valid is emitted for them. Writes already committed stay committed.
- Address is compared at full ADDR_W width; there is no wrap-around.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- Defined:
  - After reset the FSM enters CLEAR, writing 0 to words 0..DEPTH-1, one word per cycle.
  - During CLEAR: req_ready=0, busy=1, and requests are not accepted.
  - Exactly DEPTH cycles after reset deasserts, the FSM enters RUN and req_ready=1.
  - rst asserted during CLEAR restarts the sweep from word 0.
- Undefined: no CLEAR state; RUN directly after reset; contents are undefined until written.

Test Plan (DATA_W=32, DEPTH=64, RD_LAT=2 unless stated):
- Write addr 5, data 0xDEADBEEF, be=4'hF; read addr 5 next cycle -> write rsp_valid at T+2 with err=0, rdata=0; read rsp at T+3 with rdata=0xDEADBEEF.
- Byte lanes: addr 7 holds 0x11223344; write 0xAABBCCDD with be=4'b0101; read addr 7 -> 0x11BB33DD.
- Out of range: read addr 64 -> rsp_err=1, rdata=0; write addr 100 -> rsp_err=1; read addrs 0..63 afterwards -> contents unchanged.
- Streaming: 8 back-to-back reads of addrs 0..7, preloaded with values 0x100+i -> 8 consecutive rsp_valid cycles, in order, first at acceptance+2; repeat with RD_LAT=1 and RD_LAT=4 -> first pulse at +1 and +4.
- Reset mid-flight: accept read addr 5, assert rst the next cycle -> no rsp_valid for that read; rsp_valid=0, busy=0 after reset; addr 5 still holds its data.
- DMEM_CLEAR_EN:
  - After reset, req_ready=0 for exactly 64 cycles with busy=1; then reads of addrs 0, 31, 63 -> 0.
  - rst pulsed at sweep cycle 20 -> sweep restarts; req_ready rises 64 cycles after the second reset deasserts.
